// File: rtl/iter_shifter.sv
// Iterative barrel shifter: resolves one shamt bit per clock (stage k shifts by 2^k),
// giving a fixed SHW-cycle latency behind a start/done handshake.
module iter_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   shamt,
  input  logic             left,
  input  logic             logical,
  input  logic             rotate,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zero
);

  localparam int CW = (SHW > 1) ? $clog2(SHW) : 1;
  localparam logic [CW-1:0] LAST    = CW'(SHW - 1);
  localparam logic [SHW:0]  WIDTH_L = (SHW + 1)'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [SHW-1:0]   sh;
  logic [CW-1:0]    cnt;
  logic             mode_left, mode_logical, mode_rotate;
  logic             accept;
  logic [SHW:0]     amt;

  // One stage of the shifter; the accumulator MSB never changes under SRA,
  // so repeated sign fills compose into a single arithmetic shift.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] a,
    input logic [SHW:0]     n,
    input logic             l,
    input logic             lg,
    input logic             r
  );
    logic signed [WIDTH-1:0] sa;
    sa = $signed(a);
    if (r)
      return l ? ((a << n) | (a >> (WIDTH_L - n))) : ((a >> n) | (a << (WIDTH_L - n)));
    else if (l)
      return a << n;
    else if (lg)
      return a >> n;
    else
      return $unsigned(sa >>> n);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_SHIFT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign amt     = (SHW + 1)'(1) << cnt;
  assign acc_nxt = sh[cnt] ? shift_step(acc, amt, mode_left, mode_logical, mode_rotate) : acc;

  // Datapath: load on accept, one stage per SHIFT cycle, publish on the last stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc          <= '0;
      sh           <= '0;
      cnt          <= '0;
      mode_left    <= 1'b0;
      mode_logical <= 1'b0;
      mode_rotate  <= 1'b0;
      out          <= '0;
      zero         <= 1'b0;
    end else if (accept) begin
      acc          <= in;
      sh           <= shamt;
      cnt          <= '0;
      mode_left    <= left;
      mode_logical <= logical;
      mode_rotate  <= rotate;
    end else if (state == S_SHIFT) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      if (cnt == LAST) begin
        out  <= acc_nxt;
        zero <= ~|acc_nxt;
      end
    end
  end

endmodule
